// File: rtl/i2s_audio_tx.sv
// Memory-mapped audio output: sample FIFO feeding a left-justified stereo serializer.
// Each 16-bit mono sample is sent on both channels, MSB first, data changing while bclk is low.
module i2s_audio_tx #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DIV_RESET = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        bclk,
  output logic        ws,
  output logic        sdata,
  output logic        irq
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          en, en_d, underrun, overflow;
  logic [15:0]   div_q, div_act, cnt;
  logic [4:0]    bit_cnt;
  logic [15:0]   sample;

  logic [1:0]    sel;
  logic          wr_data, wr_stat, wr_ctrl, wr_div;
  logic          empty, full, flush, push, pop;
  logic          en_rise, tick, fall, frame_start;
  logic [4:0]    bit_n;
  logic [3:0]    bit_idx;
  logic [15:0]   sample_n;
  logic [31:0]   rd_n;
  logic          unused_bits;

  assign unused_bits = ^{addr[31:4], addr[1:0], wd[31:16]};

  // Bus decode and serializer next-state
  always_comb begin
    sel         = addr[3:2];
    wr_data     = we && (sel == 2'd0);
    wr_stat     = we && (sel == 2'd1);
    wr_ctrl     = we && (sel == 2'd2);
    wr_div      = we && (sel == 2'd3);
    empty       = (level == '0);
    full        = (level == LW'(DEPTH));
    flush       = wr_ctrl && wd[1];
    push        = wr_data && !full;
    en_rise     = en && !en_d;
    tick        = en && (cnt == div_act);
    fall        = tick && bclk;
    frame_start = en_rise || (fall && (bit_cnt == 5'd31));
    pop         = frame_start && !empty;
    bit_n       = bit_cnt;
    if (en_rise)   bit_n = 5'd0;
    else if (fall) bit_n = bit_cnt + 5'd1;
    sample_n    = sample;
    if (frame_start) sample_n = empty ? 16'h0000 : mem[rd_ptr];
    bit_idx     = 4'd15 - bit_n[3:0];
  end

  // Read mux, sampled into rd at every edge
  always_comb begin
    rd_n = '0;
    case (sel)
      2'd1:    rd_n = {16'h0000, 8'(level), 4'h0, overflow, underrun, full, empty};
      2'd2:    rd_n = {31'h0, en};
      2'd3:    rd_n = {16'h0000, div_q};
      default: rd_n = '0;
    endcase
  end

  assign irq = en && (level <= LW'(DEPTH / 2));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wd[15:0];
  end

  // FIFO pointers, registers and sticky flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      en       <= 1'b0;
      en_d     <= 1'b0;
      div_q    <= 16'(DIV_RESET);
      underrun <= 1'b0;
      overflow <= 1'b0;
      rd       <= '0;
    end else begin
      rd   <= rd_n;
      en_d <= en;
      if (wr_ctrl) en <= wd[0];
      if (wr_div)  div_q <= wd[15:0];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        level <= level + LW'(push) - LW'(pop);
      end
      // A same-cycle event outranks the clear
      if (wr_stat && wd[2]) underrun <= 1'b0;
      if (frame_start && empty) underrun <= 1'b1;
      if (wr_stat && wd[3]) overflow <= 1'b0;
      if (wr_data && full) overflow <= 1'b1;
    end
  end

  // Bit-clock divider and frame serializer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      div_act <= 16'(DIV_RESET);
      bclk    <= 1'b0;
      bit_cnt <= '0;
      sample  <= '0;
      ws      <= 1'b0;
      sdata   <= 1'b0;
    end else if (!en) begin
      cnt     <= '0;
      div_act <= div_q;
      bclk    <= 1'b0;
      bit_cnt <= '0;
      ws      <= 1'b0;
      sdata   <= 1'b0;
    end else begin
      if (tick) begin
        cnt     <= '0;
        div_act <= div_q;
        bclk    <= ~bclk;
      end else begin
        cnt <= cnt + 16'd1;
      end
      bit_cnt <= bit_n;
      sample  <= sample_n;
      ws      <= bit_n[4];
      sdata   <= sample_n[bit_idx];
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: register map, frame serialization, FIFO limits, irq and reset.
module tb_i2s_audio_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        bclk, ws, sdata, irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_audio_tx #(.DEPTH(16), .DIV_RESET(15)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wd(wd),
    .rd(rd), .bclk(bclk), .ws(ws), .sdata(sdata), .irq(irq)
  );

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wd = d;
    @(negedge clk);
    we = 1'b0; addr = '0; wd = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    we = 1'b0; addr = a;
    @(negedge clk);
    d = rd;
  endtask

  // Collect 32 bits (one frame) at bclk rising edges, MSB first
  task automatic capture_word(output logic [31:0] sd, output logic [31:0] wsw, output bit ok);
    logic prev;
    int   n;
    int   guard;
    sd = '0; wsw = '0; ok = 1'b1; n = 0; guard = 0; prev = bclk;
    while (n < 32) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        ok = 1'b0;
        break;
      end
      if (bclk && !prev) begin
        sd  = {sd[30:0], sdata};
        wsw = {wsw[30:0], ws};
        n++;
      end
      prev = bclk;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bclk, ws, sdata, irq} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0000", {bclk, ws, sdata, irq});
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL reset_rd: got %h expected 00000000", rd);
    end
    reset = 1'b1;
    bus_read(32'h4, v);
    checks++;
    if (v !== 32'h0000_0001) begin
      errors++; $display("FAIL reset_status: got %h expected 00000001", v);
    end
    bus_read(32'hC, v);
    checks++;
    if (v !== 32'h0000_000F) begin
      errors++; $display("FAIL reset_div: got %h expected 0000000f", v);
    end
    bus_read(32'h8, v);
    checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL reset_ctrl: got %h expected 00000000", v);
    end
  endtask

  task automatic test_basic_frame();
    logic [31:0] v, sd, wsw;
    bit ok;
    logic prev;
    int per, guard;
    bus_write(32'hC, 32'hFFFF_0001);
    bus_read(32'h1C, v);
    checks++;
    if (v !== 32'h0000_0001) begin
      errors++; $display("FAIL div_alias_readback: got %h expected 00000001", v);
    end
    bus_write(32'h0, 32'h0000_A5C3);
    bus_write(32'h8, 32'h1);
    capture_word(sd, wsw, ok);
    checks++;
    if (!ok || sd !== 32'hA5C3_A5C3) begin
      errors++; $display("FAIL basic_sdata: got %h ok=%0d expected a5c3a5c3", sd, ok);
    end
    checks++;
    if (wsw !== 32'h0000_FFFF) begin
      errors++; $display("FAIL basic_ws: got %h expected 0000ffff", wsw);
    end
    // Measure one full bclk period in clk cycles
    per = 0; guard = 0; prev = bclk;
    while (guard < 100) begin
      @(negedge clk); guard++;
      if (bclk && !prev) break;
      prev = bclk;
    end
    prev = bclk;
    while (guard < 100) begin
      @(negedge clk); guard++; per++;
      if (bclk && !prev) break;
      prev = bclk;
    end
    checks++;
    if (per !== 4) begin
      errors++; $display("FAIL bclk_period: got %0d expected 4", per);
    end
    bus_read(32'h4, v);
    checks++;
    if (v[0] !== 1'b1 || v[15:8] !== 8'h00) begin
      errors++; $display("FAIL basic_empty_after_pop: got %h expected empty=1 level=0", v);
    end
    bus_write(32'h8, 32'h0);
    @(negedge clk);
    checks++;
    if ({bclk, ws, sdata} !== 3'b000) begin
      errors++; $display("FAIL disable_outputs: got %b expected 000", {bclk, ws, sdata});
    end
    bus_write(32'h4, 32'hC);
  endtask

  task automatic test_underrun();
    logic [31:0] v, sd, wsw;
    bit ok;
    bus_write(32'h8, 32'h1);
    capture_word(sd, wsw, ok);
    checks++;
    if (!ok || sd !== 32'h0 || wsw !== 32'h0000_FFFF) begin
      errors++; $display("FAIL underrun_frame: sdata %h ws %h ok=%0d expected 00000000/0000ffff", sd, wsw, ok);
    end
    bus_write(32'h8, 32'h0);
    bus_read(32'h4, v);
    checks++;
    if (v !== 32'h0000_0005) begin
      errors++; $display("FAIL underrun_flag: got %h expected 00000005", v);
    end
    bus_write(32'h4, 32'h4);
    bus_read(32'h4, v);
    checks++;
    if (v !== 32'h0000_0001) begin
      errors++; $display("FAIL underrun_clear: got %h expected 00000001", v);
    end
  endtask

  task automatic test_fill_overflow();
    logic [31:0] v, sd, wsw, exp;
    logic [15:0] s;
    bit ok;
    for (int i = 0; i < 17; i++) bus_write(32'h0, 32'(i));
    bus_read(32'h4, v);
    checks++;
    if (v !== 32'h0000_100A) begin
      errors++; $display("FAIL fill_status: got %h expected 0000100a", v);
    end
    bus_write(32'h8, 32'h1);
    for (int f = 0; f < 17; f++) begin
      s = (f < 16) ? 16'(f) : 16'h0000;
      exp = {s, s};
      capture_word(sd, wsw, ok);
      checks++;
      if (!ok || sd !== exp) begin
        errors++; $display("FAIL fill_frame_%0d: got %h ok=%0d expected %h", f, sd, ok, exp);
      end
    end
    bus_write(32'h8, 32'h0);
    bus_write(32'h4, 32'hC);
    bus_read(32'h4, v);
    checks++;
    if (v !== 32'h0000_0001) begin
      errors++; $display("FAIL flags_clear: got %h expected 00000001", v);
    end
  endtask

  task automatic test_irq_flush();
    logic [31:0] v;
    for (int i = 0; i < 9; i++) bus_write(32'h0, 32'(16'h1000 + i));
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_disabled: got %b expected 0", irq);
    end
    bus_write(32'h8, 32'h1);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_level9: got %b expected 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_level8: got %b expected 1", irq);
    end
    bus_write(32'h8, 32'h3);
    bus_read(32'h4, v);
    checks++;
    if (v[15:8] !== 8'h00 || v[0] !== 1'b1) begin
      errors++; $display("FAIL flush_level: got %h expected level=0 empty=1", v);
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_after_flush: got %b expected 1", irq);
    end
    bus_write(32'h8, 32'h0);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_en_off: got %b expected 0", irq);
    end
    bus_write(32'h4, 32'hC);
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    logic prev;
    int rises, guard;
    bus_write(32'h0, 32'h0000_FFFF);
    bus_write(32'h8, 32'h1);
    rises = 0; guard = 0; prev = bclk;
    while (rises < 21 && guard < 2000) begin
      @(negedge clk); guard++;
      if (bclk && !prev) rises++;
      prev = bclk;
    end
    checks++;
    if (rises !== 21 || bclk !== 1'b1 || ws !== 1'b1 || sdata !== 1'b1) begin
      errors++; $display("FAIL midframe_b20: rises %0d bclk %b ws %b sdata %b expected 21 1 1 1", rises, bclk, ws, sdata);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bclk, ws, sdata, irq} !== 4'b0000 || rd !== 32'h0) begin
      errors++; $display("FAIL async_reset_outputs: got %b rd %h expected 0000 rd 0", {bclk, ws, sdata, irq}, rd);
    end
    @(negedge clk);
    reset = 1'b1;
    bus_read(32'h4, v);
    checks++;
    if (v !== 32'h0000_0001) begin
      errors++; $display("FAIL async_reset_status: got %h expected 00000001", v);
    end
    bus_read(32'hC, v);
    checks++;
    if (v !== 32'h0000_000F) begin
      errors++; $display("FAIL async_reset_div: got %h expected 0000000f", v);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_underrun();
    test_fill_overflow();
    test_irq_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached after %0d checks", checks);
    $fatal(1);
  end

endmodule
